// File: rtl/button_debounce.sv
// button_debounce: synchronise a raw pad button and debounce it into a level plus press/release/long-press pulses
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d, s;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic btn_level_q, btn_level_d, btn_press_q, btn_press_d;
  logic btn_release_q, btn_release_d, btn_long_q, btn_long_d;
  assign s = sync2_q ^ ACTIVE_LOW;
  // next-state logic: hcnt is held through RELEASE_WAIT so a release glitch cannot re-arm btn_long
  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    state_d = state_q;
    dcnt_d = dcnt_q;
    hcnt_d = hcnt_q;
    btn_level_d = btn_level_q;
    btn_press_d = 1'b0;
    btn_release_d = 1'b0;
    btn_long_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          dcnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) state_d = RELEASED;
        else if (dcnt_q == DLAST) begin
          state_d = PRESSED;
          btn_level_d = 1'b1;
          btn_press_d = 1'b1;
          hcnt_d = '0;
        end else dcnt_d = dcnt_q + 1'b1;
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          dcnt_d = '0;
        end else if (hcnt_q < HMAX) begin
          hcnt_d = hcnt_q + 1'b1;
          btn_long_d = (hcnt_q == HMAX - 1'b1);
        end
      end
      RELEASE_WAIT: begin
        if (s) state_d = PRESSED;
        else if (dcnt_q == DLAST) begin
          state_d = RELEASED;
          btn_level_d = 1'b0;
          btn_release_d = 1'b1;
        end else dcnt_d = dcnt_q + 1'b1;
      end
      default: state_d = RELEASED;
    endcase
  end
  // state, counters, synchroniser and registered outputs; synchroniser resets to the idle pad level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      state_q <= RELEASED;
      dcnt_q <= '0;
      hcnt_q <= '0;
      btn_level_q <= 1'b0;
      btn_press_q <= 1'b0;
      btn_release_q <= 1'b0;
      btn_long_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      dcnt_q <= dcnt_d;
      hcnt_q <= hcnt_d;
      btn_level_q <= btn_level_d;
      btn_press_q <= btn_press_d;
      btn_release_q <= btn_release_d;
      btn_long_q <= btn_long_d;
    end
  end
  assign btn_level = btn_level_q;
  assign btn_press = btn_press_q;
  assign btn_release = btn_release_q;
  assign btn_long = btn_long_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and random stimulus for both pad polarities against a run-length reference model
module tb_button_debounce;
  localparam int D = 4;
  localparam int L = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button = 1'b0;
  logic button_n;
  logic lvl_a, prs_a, rel_a, lng_a;
  logic lvl_b, prs_b, rel_b, lng_b;
  int checks = 0;
  int passed = 0;
  assign button_n = ~button;
  always #5 clk = ~clk;
  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .button(button),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a));
  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .button(button_n),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b));
  // Reference: a level flips once the synchronised input has disagreed with it on D+1
  // consecutive edges; hold time counts edges that are pressed both now and on the previous edge.
  logic m_s1, m_s2, m_prev, m_lvl, m_press, m_rel, m_long;
  int m_run, m_hold;
  always @(posedge clk or negedge rst) begin : model
    logic s, lvl, prs, rel, lng;
    int run, hold;
    if (!rst) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_prev <= 1'b0; m_lvl <= 1'b0;
      m_press <= 1'b0; m_rel <= 1'b0; m_long <= 1'b0; m_run <= 0; m_hold <= 0;
    end else begin
      s = m_s2; lvl = m_lvl; run = m_run; hold = m_hold;
      prs = 1'b0; rel = 1'b0; lng = 1'b0;
      run = (s != lvl) ? run + 1 : 0;
      if (lvl && s && m_prev && hold < L) begin
        hold = hold + 1;
        lng = (hold == L);
      end
      if (run == D + 1) begin
        lvl = s; run = 0;
        if (s) begin prs = 1'b1; hold = 0; end else rel = 1'b1;
      end
      m_prev <= s; m_lvl <= lvl; m_run <= run; m_hold <= hold;
      m_press <= prs; m_rel <= rel; m_long <= lng;
      m_s2 <= m_s1; m_s1 <= button;
    end
  end
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask
  task automatic chk_all();
    chk("level_a", lvl_a, m_lvl);
    chk("press_a", prs_a, m_press);
    chk("release_a", rel_a, m_rel);
    chk("long_a", lng_a, m_long);
    chk("level_b", lvl_b, m_lvl);
    chk("press_b", prs_b, m_press);
    chk("release_b", rel_b, m_rel);
    chk("long_b", lng_b, m_long);
    chk("press_xor_release", prs_a & rel_a, 1'b0);
  endtask
  task automatic step(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      button = b;
      @(negedge clk);
      chk_all();
    end
  endtask
  initial begin
    int lat, longs;
    @(negedge clk);
    button = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_level", lvl_a, 1'b0);
      chk("rst_press", prs_a, 1'b0);
      chk("rst_long", lng_a, 1'b0);
      chk("rst_level_b", lvl_b, 1'b0);
    end
    rst = 1'b1;
    lat = 0;
    for (int i = 0; i < 12 && !prs_a; i++) begin
      step(1'b1, 1);
      lat++;
    end
    chk("press_latency_from_reset", lat == D + 3, 1'b1);
    step(1'b1, 2);
    step(1'b0, 12);
    lat = 0;
    longs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1);
      if (prs_a) lat = i + 1;
      if (lng_a) longs++;
    end
    chk("clean_press_latency", lat == D + 3, 1'b1);
    chk("long_fires_once", longs == 1, 1'b1);
    lat = 0;
    for (int i = 0; i < 12 && !rel_a; i++) begin
      step(1'b0, 1);
      lat++;
    end
    chk("release_latency", lat == D + 3, 1'b1);
    step(1'b0, 4);
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 3);
      step(1'b0, 3);
    end
    step(1'b0, 8);
    chk("bounce_level", lvl_a, 1'b0);
    step(1'b1, D + 3);
    step(1'b1, 4);
    step(1'b0, 2);
    longs = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1);
      chk("glitch_no_press", prs_a, 1'b0);
      chk("glitch_no_release", rel_a, 1'b0);
      if (lng_a) longs++;
    end
    chk("glitch_long_once", longs == 1, 1'b1);
    step(1'b0, 10);
    step(1'b1, D + 6);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_level", lvl_a, 1'b0);
    chk("async_rst_level_b", lvl_b, 1'b0);
    chk("async_rst_release", rel_a, 1'b0);
    step(1'b1, 3);
    rst = 1'b1;
    step(1'b1, D + 8);
    step(1'b0, D + 4);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), $urandom_range(1, 2 * D + 4));
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), $urandom_range(L, 2 * L + 4));
    step(1'b0, 2 * D + 4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
